// File: rtl/mult_arb_pkg.sv
// Shared sizing and pipeline-entry type for the multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 2 * OP_W;
  localparam int unsigned ID_W  = $clog2(NREQ);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [RES_W-1:0]  data;
  } pipe_entry_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between requesters, result consumer and the arbiter.
interface mult_arbiter_if #(
  parameter int unsigned NREQ = mult_arb_pkg::NREQ,
  parameter int unsigned OP_W = mult_arb_pkg::OP_W
);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*OP_W-1:0]     req_a;
  logic [NREQ*OP_W-1:0]     req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [$clog2(NREQ)-1:0]  rsp_id;
  logic [2*OP_W-1:0]        rsp_result;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface

// File: rtl/mult8_pipe.sv
// Two-stage unsigned multiplier: operand register, then full-width product register.
module mult8_pipe import mult_arb_pkg::*; #(
  parameter int unsigned OpW = OP_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [OpW-1:0]   a_i,
  input  logic [OpW-1:0]   b_i,
  output logic [2*OpW-1:0] p_o
);

  logic [OpW-1:0]   a_q, a_d, b_q, b_d;
  logic [2*OpW-1:0] p_q, p_d;

  // Operands only load on a transfer, so bubbles recompute the last product and p_o holds.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (en_i) begin
      if (ld_i) begin
        a_d = a_i;
        b_d = b_i;
      end
      p_d = {{OpW{1'b0}}, a_q} * {{OpW{1'b0}}, b_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
module mult_arbiter #(
  parameter int unsigned NREQ = mult_arb_pkg::NREQ,
  parameter int unsigned OP_W = mult_arb_pkg::OP_W
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned ResW = 2 * OP_W;

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  gnt_idx, cand;
  logic            gnt_found, stall, fire;
  logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [IdW-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic [OP_W-1:0] gnt_a, gnt_b;
  logic [ResW-1:0] prod;

  mult_arb_pkg::pipe_entry_t rsp_e;

  assign stall = s2_valid_q & ~bus.rsp_ready;

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign fire  = gnt_found & ~stall & ~rst;
  assign gnt_a = bus.req_a[gnt_idx*OP_W +: OP_W];
  assign gnt_b = bus.req_b[gnt_idx*OP_W +: OP_W];

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    if (fire) begin
      ptr_d   = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + IdW'(1);
      s1_id_d = gnt_idx;
    end
    if (!stall) begin
      s1_valid_d = fire;
      s2_valid_d = s1_valid_q;
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
    end
  end

  mult8_pipe #(
    .OpW (OP_W)
  ) u_mult (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (~stall),
    .ld_i  (fire),
    .a_i   (gnt_a),
    .b_i   (gnt_b),
    .p_o   (prod)
  );

  assign rsp_e = '{valid: s2_valid_q, id: s2_id_q, data: prod};

  assign bus.rsp_valid  = rsp_e.valid;
  assign bus.rsp_id     = rsp_e.id;
  assign bus.rsp_result = rsp_e.data;
  assign bus.busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench: expected products queued at acceptance, compared when responses leave.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_arbiter_if bus ();

  mult_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [RES_W-1:0] res;
  } exp_t;

  exp_t            sb[$];
  exp_t            last_exp;
  int              n_vec = 0;
  int              n_err = 0;
  logic [OP_W-1:0] opa [NREQ][32];
  logic [OP_W-1:0] opb [NREQ][32];
  int              hd  [NREQ];
  int              cnt [NREQ];
  logic [NREQ-1:0] acc;
  logic            m_s1v, m_s2v;
  logic [ID_W-1:0] m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_req(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int idx;
    idx = (hd[i] + cnt[i]) % 32;
    opa[i][idx] = a;
    opb[i][idx] = b;
    cnt[i]++;
  endtask

  task automatic drive();
    logic [NREQ-1:0]      v;
    logic [NREQ*OP_W-1:0] va, vb;
    v = '0; va = '0; vb = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i]                = (cnt[i] > 0);
      va[i*OP_W +: OP_W]  = opa[i][hd[i]];
      vb[i*OP_W +: OP_W]  = opb[i][hd[i]];
    end
    bus.req_valid = v;
    bus.req_a     = va;
    bus.req_b     = vb;
  endtask

  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    logic            stall, fire;
    int              g, j;
    exp_t            e;
    stall = m_s2v && !bus.rsp_ready;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(m_ptr) + k) % int'(NREQ);
      if (g < 0 && bus.req_valid[j]) g = j;
    end
    fire    = !rst && !stall && (g >= 0);
    exp_rdy = '0;
    if (fire) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_s2v));
    check_eq("busy", 32'(bus.busy), 32'(m_s1v | m_s2v));
    if (m_s2v) begin
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        check_eq("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        check_eq("rsp_result", 32'(bus.rsp_result), 32'(sb[0].res));
        if (bus.rsp_ready) last_exp = sb.pop_front();
      end
    end else begin
      check_eq("hold_id", 32'(bus.rsp_id), 32'(last_exp.id));
      check_eq("hold_result", 32'(bus.rsp_result), 32'(last_exp.res));
    end
    acc = exp_rdy;
    if (fire) begin
      e.id  = ID_W'(g);
      e.res = RES_W'(opa[g][hd[g]]) * RES_W'(opb[g][hd[g]]);
      sb.push_back(e);
    end
    if (rst) begin
      m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = '0;
      sb.delete();
      last_exp = '0;
    end else if (!stall) begin
      m_s2v = m_s1v;
      m_s1v = fire;
      if (fire) m_ptr = ID_W'((g + 1) % int'(NREQ));
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        hd[i] = (hd[i] + 1) % 32;
        cnt[i]--;
      end
    end
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int i = 0; i < NREQ; i++) p += cnt[i];
    return p;
  endfunction

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = '0; last_exp = '0; acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0; cnt[i] = 0;
      for (int k = 0; k < 32; k++) begin
        opa[i][k] = '0; opb[i][k] = '0;
      end
    end
    cycle(); cycle();
    rst = 1'b0;

    // Single request: 3*5 from requester 2.
    add_req(2, 8'd3, 8'd5);
    repeat (5) cycle();

    // Contention with boundary operands, then backpressure.
    add_req(0, 8'd255, 8'd255);
    add_req(1, 8'd0,   8'd200);
    add_req(2, 8'd17,  8'd9);
    add_req(3, 8'd200, 8'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) add_req(i, OP_W'($urandom), OP_W'($urandom));
    repeat (3) cycle();
    bus.rsp_ready = 1'b0;
    repeat (3) cycle();
    bus.rsp_ready = 1'b1;
    repeat (16) cycle();

    // Reset with two entries in flight; first grant afterwards must be the lowest index.
    add_req(0, 8'd11, 8'd12);
    add_req(1, 8'd13, 8'd14);
    cycle(); cycle();
    add_req(3, 8'd21, 8'd22);
    add_req(1, 8'd23, 8'd24);
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) cycle();

    // Random traffic and consumer backpressure.
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 2) == 0 && cnt[i] < 20)
          add_req(i, OP_W'($urandom), OP_W'($urandom));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 400 && (pending() + sb.size() > 0 || m_s1v || m_s2v); c++) cycle();
    check_eq("drain", 32'(pending() + sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
